alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request side and a valid/ready result side.
// Single-cycle ops complete one cycle after acceptance; MUL runs a radix-2
// shift-add loop for WIDTH cycles before presenting its result.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               overflow_o
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_LW   = 4'd2,  OP_SW   = 4'd3,
    OP_ADDU = 4'd4,  OP_SUBU = 4'd5,  OP_SLT  = 4'd6,  OP_BLEZ = 4'd7,
    OP_SRA  = 4'd8,  OP_SRAV = 4'd9,  OP_LUI  = 4'd10, OP_SLTU = 4'd11,
    OP_SLL  = 4'd12, OP_MUL  = 4'd13, OP_BGTZ = 4'd14, OP_ILL  = 4'd15
  } op_t;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);
  localparam logic [WIDTH-2:0]   ZPAD = '0;

  state_t             state, state_nxt;
  logic               accept, is_mul, mul_last, alu_ovf;
  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic [WIDTH-1:0]   mcand, mplier, acc, acc_step;
  logic [SHAMT_W-1:0] count;

  assign accept   = valid_i && ready_o;
  assign is_mul   = (op_i == OP_MUL);
  assign mul_last = (state == MUL) && (count == LAST);
  assign sum      = src1_i + src2_i;
  assign diff     = src1_i - src2_i;
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs; ready_i feeds ready_o directly in DONE.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nxt = is_mul ? MUL : DONE;
      end
      MUL: begin
        if (count == LAST) state_nxt = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) state_nxt = valid_i ? (is_mul ? MUL : DONE) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle operation results computed from the live request operands.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_t'(op_i))
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_LW, OP_SW, OP_ADDU: begin
        alu_res = sum;
        alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUBU: begin
        alu_res = diff;
        alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  alu_res = {ZPAD, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU: alu_res = {ZPAD, src1_i < src2_i};
      OP_BLEZ: alu_res = {ZPAD, src1_i[WIDTH-1] || (src1_i == '0)};
      OP_BGTZ: alu_res = {ZPAD, !src1_i[WIDTH-1] && (src1_i != '0)};
      OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
      OP_SRAV: alu_res = $unsigned($signed(src2_i) >>> src1_i[SHAMT_W-1:0]);
      OP_LUI:  alu_res = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_res = src2_i << shamt_i;
      default: alu_res = '0;
    endcase
  end

  // Result registers and multiplier; outputs only change on accept or MUL completion,
  // so they hold steady while a result waits for ready_i.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= src1_i;
        mplier <= src2_i;
        acc    <= '0;
        count  <= '0;
      end else begin
        result_o   <= alu_res;
        zero_o     <= (alu_res == '0);
        overflow_o <= alu_ovf;
      end
    end else if (state == MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (mul_last) begin
        result_o   <= acc_step;
        zero_o     <= (acc_step == '0);
        overflow_o <= 1'b0;
        count      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  op_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;

  int compared = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] sra_ref(input logic [31:0] b, input int unsigned s);
    logic [31:0] ones, r;
    ones = 32'hFFFF_FFFF;
    r = b >> s;
    if (b[31]) r = r | ~(ones >> s);
    return r;
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2, 4'd3, 4'd4: return a + b;
      4'd5:  return a - b;
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (sa <= 0) ? 32'd1 : 32'd0;
      4'd8:  return sra_ref(b, int'(sh));
      4'd9:  return sra_ref(b, int'(a % 32));
      4'd10: return b << 16;
      4'd11: return (a < b) ? 32'd1 : 32'd0;
      4'd12: return b << sh;
      4'd13: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      4'd14: return (sa > 0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, b);
    longint s;
    if (op == 4'd2 || op == 4'd3 || op == 4'd4)
      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd5)
      s = longint'($signed(a)) - longint'($signed(b));
    else
      return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Drives one request with ready_i=1 and returns the first presented result and its latency.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                        output logic [31:0] r, output logic z, ov, output int lat);
    ready_i = 1'b1;
    lat = 0;
    while (!ready_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    op_i = op; src1_i = a; src2_i = b; shamt_i = sh; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; op_i = 4'($urandom);
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    r = result_o; z = zero_o; ov = overflow_o;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1 || overflow_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: valid=%b result=%h zero=%b ovf=%b required 0/00000000/1/0",
               valid_o, result_o, zero_o, overflow_o);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_n = 1'b1;
    @(posedge clk_i); #1;
    compared++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b valid=%b required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_directed;
    logic [3:0]  ops[6];
    logic [31:0] as[6], bs[6];
    logic [4:0]  shs[6];
    logic [31:0] r, er;
    logic z, ov, eov;
    int lat;
    ops = '{4'd4, 4'd8, 4'd11, 4'd6, 4'd10, 4'd15};
    as  = '{32'h7FFF_FFFF, 32'd0, 32'd1, 32'd1, 32'd0, 32'h1234_5678};
    bs  = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'h9ABC_DEF0};
    shs = '{5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd7};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], shs[i], r, z, ov, lat);
      er  = ref_res(ops[i], as[i], bs[i], shs[i]);
      eov = ref_ovf(ops[i], as[i], bs[i]);
      compared++;
      if (r !== er || z !== (er == 32'd0) || ov !== eov || lat !== 1) begin
        mismatched++;
        $display("FAIL directed op=%0d: result=%h zero=%b ovf=%b lat=%0d required %h/%b/%b/1",
                 ops[i], r, z, ov, lat, er, (er == 32'd0), eov);
      end
    end
  endtask

  task automatic test_mul;
    int busy, lat;
    logic [31:0] r;
    op_i = 4'd13; src1_i = 32'hFFFF_FFFD; src2_i = 32'd7; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    // Hammer the input with a competing request while busy; it must be ignored.
    op_i = 4'd0; src1_i = 32'hFFFF_FFFF; src2_i = 32'hFFFF_FFFF;
    busy = 0; lat = 1;
    while (!valid_o && lat < 100) begin
      if (ready_o === 1'b0) busy++;
      @(posedge clk_i); #1; lat++;
    end
    valid_i = 1'b0;
    r = result_o;
    compared++;
    if (busy !== 32 || lat !== 33) begin
      mismatched++;
      $display("FAIL mul_timing: busy=%0d lat=%0d required 32/33", busy, lat);
    end
    compared++;
    if (r !== 32'hFFFF_FFEB || zero_o !== 1'b0 || overflow_o !== 1'b0) begin
      mismatched++;
      $display("FAIL mul_result: result=%h zero=%b ovf=%b required ffffffeb/0/0", r, zero_o, overflow_o);
    end
    @(posedge clk_i); #1;
    compared++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL mul_release: valid=%b ready=%b required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_backpressure;
    int bad;
    ready_i = 1'b0;
    op_i = 4'd5; src1_i = 32'd5; src2_i = 32'd5; valid_i = 1'b1;
    @(posedge clk_i); #1;
    op_i = 4'd1; src1_i = 32'hA5A5_A5A5;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1) bad++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL backpressure_hold: unstable cycles=%0d required 0", bad);
    end
    ready_i = 1'b1;
    #1;
    compared++;
    if (ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure_ready_comb: ready=%b required 1", ready_o);
    end
    @(posedge clk_i); #1;
    compared++;
    if (valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_release: valid=%b required 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    ready_i = 1'b1;
    op_i = 4'd13; src1_i = 32'd12345; src2_i = 32'd678; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) begin @(posedge clk_i); #1; end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (valid_o !== 1'b0 || result_o !== 32'd0 || zero_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_mul: valid=%b result=%h zero=%b required 0/00000000/1",
               valid_o, result_o, zero_o);
    end
    @(negedge clk_i) rst_n = 1'b1;
    @(posedge clk_i); #1;
    compared++;
    if (ready_o !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_mul_ready: ready=%b required 1", ready_o);
    end
    seen = 0;
    repeat (40) begin if (valid_o !== 1'b0) seen++; @(posedge clk_i); #1; end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL reset_mid_mul_stale: valid cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    ready_i = 1'b1;
    op_i = 4'd0; src1_i = a; src2_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    compared++;
    if (valid_o !== 1'b1 || result_o !== (a & b)) begin
      mismatched++;
      $display("FAIL b2b_and: valid=%b result=%h required 1/%h", valid_o, result_o, a & b);
    end
    op_i = 4'd1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    compared++;
    if (valid_o !== 1'b1 || result_o !== (a | b)) begin
      mismatched++;
      $display("FAIL b2b_or: valid=%b result=%h required 1/%h", valid_o, result_o, a | b);
    end
    @(posedge clk_i); #1;
    compared++;
    if (valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_end: valid=%b required 0", valid_o);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b, r, er;
    logic [4:0]  sh;
    logic z, ov, eov;
    int lat, elat;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick_operand(); b = pick_operand(); sh = 5'($urandom);
      run_op(op, a, b, sh, r, z, ov, lat);
      er   = ref_res(op, a, b, sh);
      eov  = ref_ovf(op, a, b);
      elat = (op == 4'd13) ? 33 : 1;
      compared++;
      if (r !== er || z !== (er == 32'd0) || ov !== eov || lat !== elat) begin
        mismatched++;
        $display("FAIL random op=%0d a=%h b=%h sh=%0d: result=%h zero=%b ovf=%b lat=%0d required %h/%b/%b/%0d",
                 op, a, b, sh, r, z, ov, lat, er, (er == 32'd0), eov, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
